fetch_buffer: RTL

Instruction fetch buffer between the IF stage and the decode stage of the MIPS pipeline. It queues fetched instruction words with their PC and fetch-exception tag, then presents the oldest entry to decode as `instrD`/`pcD`. It absorbs instruction-SRAM latency and decode stalls, and is emptied in one cycle on a branch redirect or exception flush. When the queue is empty, decode sees a NOP (32'h0), so the main decoder raises no reserved-instruction exception on a bubble.

---
 rtl/fetch_buffer_pkg.sv | 15 +
 rtl/fetch_buffer_if.sv | 31 +++
 rtl/fetch_buffer.sv | 76 +++++++
 3 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared types for the IF->ID fetch buffer: the queued entry layout and the
// NOP word that decode sees when no instruction is available.
package fetch_buffer_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  localparam fetch_entry_t ENTRY_NOP = '{pc: 32'h0, instr: INSTR_NOP, adel: 1'b0};

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle for fetch_buffer.
// master = IF/ID pipeline side, slave = the buffer itself.
interface fetch_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_adel;
  logic        if_ready;

  logic        stallD;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        adelD;
  logic [AW:0] countD;

  modport master (
    output if_valid, if_instr, if_pc, if_adel, stallD,
    input  if_ready, validD, instrD, pcD, adelD, countD
  );

  modport slave (
    input  if_valid, if_instr, if_pc, if_adel, stallD,
    output if_ready, validD, instrD, pcD, adelD, countD
  );

endinterface

// File: rtl/fetch_buffer.sv
// Show-ahead instruction queue between IF and ID, single-cycle flush.
// Define FETCH_BUF_BYPASS_EN to forward a fetched word straight to decode when empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           flush,
  fetch_buffer_if.slave  fb
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  fetch_entry_t  in_e, head;
  logic          empty, full, byp;
  logic          push, wr_en, rd_adv;

  assign in_e = '{pc: fb.if_pc, instr: fb.if_instr, adel: fb.if_adel};

  always_comb begin
    empty = (cnt == '0);
    full  = (cnt == CNT_FULL);
`ifdef FETCH_BUF_BYPASS_EN
    byp   = empty && fb.if_valid && !flush;
`else
    byp   = 1'b0;
`endif
    push   = fb.if_valid && !full && !flush;
    // A bypassed word consumed by decode this cycle never touches the array.
    wr_en  = push && !(byp && !fb.stallD);
    rd_adv = !empty && !fb.stallD && !flush;
    if (byp)        head = in_e;
    else if (empty) head = ENTRY_NOP;
    else            head = mem[rp];
  end

  assign fb.if_ready = !full;
  assign fb.validD   = !empty || byp;
  assign fb.instrD   = head.instr;
  assign fb.pcD      = head.pc;
  assign fb.adelD    = head.adel;
  assign fb.countD   = cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en)  wp <= wp + AW'(1);
      if (rd_adv) rp <= rp + AW'(1);
      case ({wr_en, rd_adv})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; entries are only read while cnt covers them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= in_e;
  end

endmodule
